bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Digit-serial, multi-digit packed-BCD adder. It processes one decimal digit per clock, least-significant digit first, and carries between digits in a register. It is the addition-side counterpart to the team's BCD subtractor and feeds the same decimal datapath, and a start/done handshake lets a controller sequence it. Operands are latched at start, so the source may change them while the adder is busy.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Must be at least 1.
- `clk`, input, 1 bit: rising-edge clock.
- `rst_n`, input, 1 bit: reset, synchronous and active-low.
- `start`, input, 1 bit: request an operation. Sampled only in IDLE.
- `a`, input, 4*DIGITS bits: packed BCD operand. Digit i is `a[4i+3:4i]`.
- `b`, input, 4*DIGITS bits: packed BCD operand, same packing as `a`.
- `cin`, input, 1 bit: carry-in to digit 0.
- `busy`, output, 1 bit: high in the ADD and DONE states.
- `done`, output, 1 bit: single-cycle pulse meaning the result is valid.
- `sum`, output, 4*DIGITS bits: packed BCD result.
- `cout`, output, 1 bit: decimal carry out of the top digit.
- `err`, output, 1 bit: at least one operand digit was greater than 9 in the last operation.

## Operation
- States: IDLE, ADD, DONE.
- IDLE to ADD happens when `start` is 1.
  - Latch `a`, `b` and `cin`.
  - Clear `sum`, `cout` and `err`.
  - Set digit index `k` to 0.
- ADD, every cycle, for digit k:
  - raw = a_k + b_k + carry, 5 bits wide.
  - If raw > 9: digit = (raw + 6)[3:0] and carry = 1.
  - Otherwise: digit = raw[3:0] and carry = 0.
  - Write the digit into `sum[4k+3:4k]`.
  - If a_k > 9 or b_k > 9, set `err`. `err` is sticky for the operation.
  - Invalid digits still go through the correction rule; the result is defined but not meaningful.
- ADD to DONE happens after digit DIGITS-1 is processed. At that point the final carry is registered into `cout`.
- DONE to IDLE is unconditional. `done` is 1 only in DONE.
- `sum`, `cout` and `err` hold their values until the next accepted start.
- `start` is ignored in ADD and DONE. There is no queuing, and a start that arrives during DONE is dropped.
- Reset (`rst_n` = 0 at a clock edge):
  - State goes to IDLE; `sum`, `cout`, `err`, `busy` and `done` all go to 0.
  - Reset during an operation aborts it, and no `done` is produced.

## Timing
- Latency: `start` sampled at edge T gives `done` high during the cycle after edge T+DIGITS+1 (DIGITS ADD cycles, then DONE).
- Throughput: one operation per DIGITS+2 cycles.
- `busy` rises one cycle after the accepted start and falls together with `done`.
- `busy` is low during the DONE-to-IDLE return cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Worst-case valid raw sum is 9+9+1 = 19. Worst-case invalid raw sum is 15+15+1 = 31, which still fits in 5 bits, and the +6 correction is truncated to 4 bits.
- The digit index counter needs clog2(DIGITS) bits, minimum 1.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum (IDLE, ADD, DONE);
  - the constant `BCD_MAX` = 4'd9;
  - the constant `BCD_CORR` = 4'd6.
  - The BCD subtractor should reuse these constants.
- Sub-module `bcd_digit_adder`:
  - combinational;
  - inputs: `x[3:0]`, `y[3:0]`, `ci`;
  - outputs: `s[3:0]`, `co`, `bad`.
  - One instance is used, driven by the currently selected digit from the latched operands.
- Top level contains the FSM, the index counter, the operand shift or mux, and the result registers.

## Test plan
- DIGITS=4, `a`=0x1234, `b`=0x5678, `cin`=0, start at T: `sum`=0x6912, `cout`=0, `err`=0, `done` pulses exactly once, 5 cycles after T.
- `a`=0x9999, `b`=0x0001, `cin`=0: `sum`=0x0000, `cout`=1; the carry ripples through all 4 ADD cycles.
- `a`=0x0000, `b`=0x0000, `cin`=1: `sum`=0x0001, `cout`=0. A second run with `a`=0x4999, `b`=0x5000, `cin`=1 gives `sum`=0x0000, `cout`=1.
- `a`=0x00A0, `b`=0x0001: `err`=1 at `done`. A following valid operation clears `err` to 0.
- Pulse `start` again at cycle T+2 with new operands: it is ignored; the result matches the first operands and there is exactly one `done`.
- Assert `rst_n`=0 at T+2: the next cycle shows `busy`=0, `sum`=0, `cout`=0, `err`=0, and no `done` appears. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the decimal datapath: adder FSM
//                states and BCD digit constants used by the adder and
//                subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest legal BCD digit value
    localparam logic [3:0] BCD_MAX  = 4'd9;
    // Correction added when a binary digit sum passes nine
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage
`default_nettype wire

// File: rtl/bcd_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder_if
//  Description : Start/done handshake and operand/result bus of the
//                digit-serial BCD adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    // Controller side
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    // Adder side
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adder
//  Description : Combinational single-digit BCD adder with decimal
//                correction and invalid-digit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  wire logic [3:0] x,
    input  wire logic [3:0] y,
    input  wire logic       ci,
    output logic      [3:0] s,
    output logic            co,
    output logic            bad
);

    logic [4:0] raw;

    // Binary sum then decimal correction; invalid inputs still follow the
    // same rule, with the corrected value truncated to 4 bits.
    always_comb begin
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        s   = raw[3:0];
        co  = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            s  = raw[3:0] + BCD_CORR;
            co = 1'b1;
        end
        bad = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder
//  Description : Digit-serial packed-BCD adder, one digit per clock, LSD
//                first, with start/done handshake and latched operands.
//                busy/done are registered from the state, so they appear one
//                cycle after the state they describe.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_serial_adder_if.slave  bus
);

    localparam int            W      = 4 * DIGITS;
    localparam int            KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    state_t          state;
    state_t          state_next;
    logic [KW-1:0]   k;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    sum_q;
    logic            carry;
    logic            cout_q;
    logic            err_q;
    logic            busy_q;
    logic            done_q;
    logic            accept;
    logic [3:0]      dig_s;
    logic            dig_co;
    logic            dig_bad;

    // A start is taken only when idle and no completion is being shown
    assign accept = (state == ST_IDLE) && !done_q && bus.start;

    // Operands shift right, so the current digit is always the low nibble
    bcd_digit_adder u_digit (
        .x   (a_sh[3:0]),
        .y   (b_sh[3:0]),
        .ci  (carry),
        .s   (dig_s),
        .co  (dig_co),
        .bad (dig_bad)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)      state_next = ST_ADD;
            ST_ADD:  if (k == K_LAST) state_next = ST_DONE;
            ST_DONE:                  state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Operand latch, digit iteration and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            k      <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state == ST_ADD) || (state == ST_DONE);
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        err_q  <= 1'b0;
                        k      <= '0;
                    end
                end
                ST_ADD: begin
                    a_sh              <= a_sh >> 4;
                    b_sh              <= b_sh >> 4;
                    sum_q[{k, 2'b00} +: 4] <= dig_s;
                    carry             <= dig_co;
                    err_q             <= err_q | dig_bad;
                    k                 <= k + KW'(1);
                    if (k == K_LAST) cout_q <= dig_co;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_adder
//  Description : Self-checking bench for bcd_serial_adder (DIGITS = 4) with
//                an expected-result queue popped on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_done;
    exp_t exp_q[$];

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digit addition straight from the arithmetic rule
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        exp_t r;
        int   c;
        int   raw;
        int   x;
        int   y;
        r = '0;
        c = int'(mc);
        for (int i = 0; i < DIGITS; i++) begin
            x   = int'(ma[4*i +: 4]);
            y   = int'(mb[4*i +: 4]);
            raw = x + y + c;
            if (x > 9 || y > 9) r.e = 1'b1;
            if (raw > 9) begin
                r.s[4*i +: 4] = 4'((raw + 6) % 16);
                c = 1;
            end else begin
                r.s[4*i +: 4] = 4'(raw);
                c = 0;
            end
        end
        r.c = (c != 0);
        return r;
    endfunction

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",  32'(bus.sum),  32'(e.s));
                check("cout", 32'(bus.cout), 32'(e.c));
                check("err",  32'(bus.err),  32'(e.e));
            end
        end
    end

    // One operation; optionally re-pulses start with other operands mid-run
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input exp_t e, input bit reissue);
        int n;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.cin   = tc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        check("busy_at_T", 32'(bus.busy), 32'd0);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("busy_rise", 32'(bus.busy), 32'd1);
                if (reissue) begin
                    bus.start = 1'b1;
                    bus.a     = 16'h1111;
                    bus.b     = 16'h2222;
                    bus.cin   = 1'b1;
                end
            end
            if (n == 2) bus.start = 1'b0;
            if (bus.done) break;
        end
        check("latency", 32'(n), 32'(DIGITS + 1));
        check("busy_at_done", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        run_op(ta, tb_, tc, model(ta, tb_, tc), 1'b0);
    endtask

    initial begin
        int   done_before;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks  = 0;
        n_fail    = 0;
        n_done    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;

        // Directed cases with hand-derived results
        run_op(16'h1234, 16'h5678, 1'b0, '{s: 16'h6912, c: 1'b0, e: 1'b0}, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, e: 1'b0}, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, '{s: 16'h0001, c: 1'b0, e: 1'b0}, 1'b0);
        run_op(16'h4999, 16'h5000, 1'b1, '{s: 16'h0000, c: 1'b1, e: 1'b0}, 1'b0);
        // 0xA+0x0 = 10 -> corrected digit 0, carry into the next digit
        run_op(16'h00A0, 16'h0001, 1'b0, '{s: 16'h0101, c: 1'b0, e: 1'b1}, 1'b0);
        run_op(16'h0005, 16'h0004, 1'b0, '{s: 16'h0009, c: 1'b0, e: 1'b0}, 1'b0);
        // 0xF+0xF+1 = 31 -> (31+6) mod 16 = 5, carry 1
        run_op(16'h000F, 16'h000F, 1'b1, '{s: 16'h0015, c: 1'b0, e: 1'b1}, 1'b0);

        // Start during ADD is ignored; only the first operands complete
        done_before = n_done;
        run_op(16'h2500, 16'h2500, 1'b0, '{s: 16'h5000, c: 1'b0, e: 1'b0}, 1'b1);
        repeat (DIGITS + 4) @(posedge clk);
        #1;
        check("ignored_start_done_count", 32'(n_done - done_before), 32'd1);

        // Reset in the middle of an operation aborts it
        done_before = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_err",  32'(bus.err),  32'd0);
        repeat (DIGITS + 4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done - done_before), 32'd0);
        run_op(16'h0777, 16'h0333, 1'b0, '{s: 16'h1110, c: 1'b0, e: 1'b0}, 1'b0);

        // Random valid-BCD operands against the reference
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            run_model(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
